// File: rtl/rv_skidbuf_pkg.sv
// -----------------------------------------------------------------------------
// rv_skidbuf_pkg
//
// Shared definitions for the rv_skidbuf slice:
//   - RV_SKIDBUF_WIDTH : default payload width in bits
//   - sb_state_t       : occupancy state of the skid buffer
//   - state_occ()      : number of held entries for a given state
// -----------------------------------------------------------------------------
package rv_skidbuf_pkg;

    localparam int RV_SKIDBUF_WIDTH = 2;

    // The encoding is fixed so that the state value reads directly as the
    // number of held entries when probed.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } sb_state_t;

    // Entry count held in each state; the unused encoding reports 0.
    function automatic logic [1:0] state_occ(input sb_state_t s);
        logic [1:0] n;
        case (s)
            EMPTY:   n = 2'd0;
            BUSY:    n = 2'd1;
            FULL:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage : rv_skidbuf_pkg

// File: rtl/rv_dffe_sr.sv
// -----------------------------------------------------------------------------
// rv_dffe_sr
//
// WIDTH-bit enable flop with synchronous, active-high clear. Clear has
// priority over the enable.
//
// Ports:
//   clk : clock, rising edge
//   clr : synchronous clear to all-zero
//   en  : load d on the next rising edge
//   d   : data in
//   q   : registered data out
// -----------------------------------------------------------------------------
module rv_dffe_sr
    import rv_skidbuf_pkg::*;
#(
    parameter int WIDTH = RV_SKIDBUF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : rv_dffe_sr

// File: rtl/rv_skidbuf.sv
// -----------------------------------------------------------------------------
// rv_skidbuf
//
// Two-entry skid buffer between a valid/ready producer and consumer. The
// "main" register always drives out_data; the "skid" register catches the
// one beat that arrives while the consumer stalls, so in_ready can be a pure
// decode of registered state and never sees out_ready combinationally.
//
// Handshake: a beat transfers on a rising clk edge when valid and ready are
// both high in the preceding cycle (in_fire = in_valid & in_ready,
// out_fire = out_valid & out_ready). Once out_valid is high, out_data holds
// steady until out_fire.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset; empties the buffer, zeroes data
//   flush     : synchronous discard of all held entries (data not cleared)
//   in_valid  : upstream offers in_data
//   in_data   : upstream payload, WIDTH bits
//   in_ready  : buffer can accept (decoded from state only)
//   out_valid : out_data is valid
//   out_data  : payload to downstream, WIDTH bits (always the main register)
//   out_ready : downstream consumes this cycle
//   occ       : number of held entries, 0..2
// -----------------------------------------------------------------------------
module rv_skidbuf
    import rv_skidbuf_pkg::*;
#(
    parameter int WIDTH = RV_SKIDBUF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occ
);

    sb_state_t        state_q;
    sb_state_t        state_d;

    logic             in_fire;
    logic             out_fire;

    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // ------------------------------------------------------------------
    // State register. rst wins over flush simply by being checked first.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) state_d = BUSY;
                end
                BUSY: begin
                    // out_valid is high here, so out_ready alone decides
                    // whether the held beat leaves this cycle.
                    if (in_fire && !out_ready) begin
                        state_d = FULL;
                    end else if (out_fire && !in_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low, so nothing can enter this cycle.
                    if (out_fire) state_d = BUSY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode: registered state only.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            BUSY: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
        occ = state_occ(state_q);
    end

    // ------------------------------------------------------------------
    // Datapath enables. A flush suppresses all loads so a beat accepted
    // in the flush cycle never lands in either register.
    // ------------------------------------------------------------------
    always_comb begin
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY: begin
                    main_en = in_fire;
                end
                BUSY: begin
                    // Pass-through when drained, otherwise park in skid.
                    main_en = in_fire & out_ready;
                    skid_en = in_fire & ~out_ready;
                end
                FULL: begin
                    main_en        = out_ready;
                    main_from_skid = 1'b1;
                end
                default: begin
                    main_en = 1'b0;
                end
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    rv_dffe_sr #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .clr (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    rv_dffe_sr #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .clr (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

    assign out_data = main_q;

endmodule : rv_skidbuf
